// File: rtl/vga_timing_if.sv
// vga_timing_if: raster run enable plus scan position, sync, blank and strobes.
// Carries frame_count only when VGA_TIMING_FRAMECNT_EN is defined.
interface vga_timing_if;
  logic        en;
  logic [15:0] x;
  logic [15:0] y;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        line_start;
  logic        frame_start;
  logic        vblank_start;
`ifdef VGA_TIMING_FRAMECNT_EN
  logic [15:0] frame_count;

  modport master (
    input  en,
    output x, y, hsync, vsync, blank,
    output line_start, frame_start, vblank_start,
    output frame_count
  );

  modport slave (
    output en,
    input  x, y, hsync, vsync, blank,
    input  line_start, frame_start, vblank_start,
    input  frame_count
  );
`else
  modport master (
    input  en,
    output x, y, hsync, vsync, blank,
    output line_start, frame_start, vblank_start
  );

  modport slave (
    output en,
    input  x, y, hsync, vsync, blank,
    input  line_start, frame_start, vblank_start
  );
`endif
endinterface

// File: rtl/vga_timing.sv
// vga_timing: pixel-clock raster generator (x/y, sync, blank, strobes).
// Optional frame counter output enabled by VGA_TIMING_FRAMECNT_EN.
module vga_timing #(
  parameter int H_VISIBLE = 1280,
  parameter int H_FRONT   = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BACK    = 220,
  parameter int V_VISIBLE = 720,
  parameter int V_FRONT   = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BACK    = 20,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  vga_timing_if.master bus
);

  localparam int H_TOT_I =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT_I =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] H_LAST =
    16'(H_TOT_I - 1);
  localparam logic [15:0] V_LAST =
    16'(V_TOT_I - 1);
  localparam logic [15:0] H_VIS =
    16'(H_VISIBLE);
  localparam logic [15:0] V_VIS =
    16'(V_VISIBLE);
  localparam logic [15:0] HS_BEG =
    16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END =
    16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_BEG =
    16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END =
    16'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [15:0] r_x;
  logic [15:0] r_y;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank;
  logic        r_ls;
  logic        r_fs;
  logic        r_vbs;

  logic [15:0] w_nx;
  logic [15:0] w_ny;
  logic        w_x_last;
  logic        w_y_last;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_blank;
  logic        w_ls;
  logic        w_fs;
  logic        w_vbs;

  assign w_x_last = (r_x == H_LAST);
  assign w_y_last = (r_y == V_LAST);

  // next raster position: x steps, y steps on x wrap, hold when en=0
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (bus.en) begin
      if (w_x_last) begin
        w_nx = '0;
        w_ny = w_y_last ? '0 : r_y + 16'd1;
      end else begin
        w_nx = r_x + 16'd1;
      end
    end
  end

  // decode sync/blank/strobes from the position about to be presented
  always_comb begin
    w_hs_act = (w_nx >= HS_BEG) && (w_nx < HS_END);
    w_vs_act = (w_ny >= VS_BEG) && (w_ny < VS_END);
    w_blank  = (w_nx >= H_VIS) || (w_ny >= V_VIS);
    w_ls     = bus.en && (w_nx == '0);
    w_fs     = w_ls && (w_ny == '0);
    w_vbs    = w_ls && (w_ny == V_VIS);
  end

  // position and decoded outputs registered together for zero skew
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_blank <= 1'b1;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
      r_vbs   <= 1'b0;
    end else begin
      r_x     <= w_nx;
      r_y     <= w_ny;
      r_hs    <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs    <= w_vs_act ? VS_POL : ~VS_POL;
      r_blank <= w_blank;
      r_ls    <= w_ls;
      r_fs    <= w_fs;
      r_vbs   <= w_vbs;
    end
  end

  assign bus.x            = r_x;
  assign bus.y            = r_y;
  assign bus.hsync        = r_hs;
  assign bus.vsync        = r_vs;
  assign bus.blank        = r_blank;
  assign bus.line_start   = r_ls;
  assign bus.frame_start  = r_fs;
  assign bus.vblank_start = r_vbs;

`ifdef VGA_TIMING_FRAMECNT_EN
  logic [15:0] r_fcnt;

  // frame counter steps on the edge that presents frame_start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fcnt <= '0;
    end else if (w_fs) begin
      r_fcnt <= r_fcnt + 16'd1;
    end
  end

  assign bus.frame_count = r_fcnt;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: random-enable raster run against a linear-position model.
// Two instances cover active-high and active-low sync polarity.
module tb_vga_timing;

  localparam int HV = 16;
  localparam int HF = 4;
  localparam int HS = 3;
  localparam int HB = 5;
  localparam int VV = 10;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int NP = HT * VT;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  vga_timing_if u_if_p ();
  vga_timing_if u_if_n ();

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF),
    .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF),
    .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut_p (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(u_if_p.master)
  );

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF),
    .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF),
    .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_n (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(u_if_n.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int m_p    = 0;
  bit m_clk  = 1'b0;
  bit m_enp  = 1'b0;
  int m_fcnt = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
  endtask

  function automatic logic [5:0] exp_flags(
    input bit ph,
    input bit pv
  );
    int  mx;
    int  my;
    bit  hs;
    bit  vs;
    bit  bl;
    bit  ls;
    mx = m_p % HT;
    my = m_p / HT;
    if (!m_clk) return {~ph, ~pv, 1'b1, 3'b000};
    hs = (mx >= HV + HF) && (mx < HV + HF + HS);
    vs = (my >= VV + VF) && (my < VV + VF + VS);
    bl = (mx >= HV) || (my >= VV);
    ls = m_enp && (mx == 0);
    return {hs ? ph : ~ph, vs ? pv : ~pv, bl,
            ls, ls && (my == 0), ls && (my == VV)};
  endfunction

  task automatic compare_all();
    chk("x_p", 32'(u_if_p.x), 32'(m_p % HT));
    chk("y_p", 32'(u_if_p.y), 32'(m_p / HT));
    chk("flags_p",
        32'({u_if_p.hsync, u_if_p.vsync,
             u_if_p.blank, u_if_p.line_start,
             u_if_p.frame_start,
             u_if_p.vblank_start}),
        32'(exp_flags(1'b1, 1'b1)));
    chk("x_n", 32'(u_if_n.x), 32'(m_p % HT));
    chk("y_n", 32'(u_if_n.y), 32'(m_p / HT));
    chk("flags_n",
        32'({u_if_n.hsync, u_if_n.vsync,
             u_if_n.blank, u_if_n.line_start,
             u_if_n.frame_start,
             u_if_n.vblank_start}),
        32'(exp_flags(1'b0, 1'b0)));
`ifdef VGA_TIMING_FRAMECNT_EN
    chk("fcnt", 32'(u_if_p.frame_count),
        32'(m_fcnt & 16'hFFFF));
`endif
  endtask

  task automatic model_reset();
    m_p   = 0;
    m_clk = 1'b0;
    m_enp = 1'b0;
    m_fcnt = 0;
  endtask

  task automatic step(input bit e);
    u_if_p.en = e;
    u_if_n.en = e;
    @(posedge clk_i);
    m_clk = 1'b1;
    m_enp = e;
    if (e) begin
      m_p = (m_p + 1) % NP;
      if (m_p == 0) m_fcnt++;
    end
    @(negedge clk_i);
    compare_all();
  endtask

  initial begin
    bit found;
    u_if_p.en = 1'b0;
    u_if_n.en = 1'b0;
    model_reset();
    @(negedge clk_i);
    compare_all();
    @(negedge clk_i);
    rst_i = 1'b0;
    compare_all();

    for (int i = 0; i < HT; i++) step(1'b1);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 7) != 0);

    found = 1'b0;
    for (int i = 0; i <= NP && !found; i++) begin
      if (m_p == 10 * HT + 5) found = 1'b1;
      else step(1'b1);
    end
    chk("seek_hold", 32'(found), 32'd1);
    for (int i = 0; i < 37; i++) step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);

    found = 1'b0;
    for (int i = 0; i <= NP && !found; i++) begin
      if (m_p % HT == HV + HF + 1) found = 1'b1;
      else step(1'b1);
    end
    chk("seek_hsync", 32'(found), 32'd1);
    chk("pre_rst_hs", 32'(u_if_p.hsync), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("async_hs", 32'(u_if_p.hsync), 32'd0);
    compare_all();
    @(negedge clk_i);
    compare_all();
    rst_i = 1'b0;

    for (int i = 0; i < 3 * NP; i++) step(1'b1);
    chk("frames_run", 32'(m_fcnt), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
